// File: rtl/fifo_drain_serializer.sv
// Drains 64-bit FIFO entries and emits each as two 32-bit valid/ready beats, low word first.
// Optional `FIFO_DRAIN_CNT_EN adds a 16-bit wrapping count of popped entries on drain_cnt.
module fifo_drain_serializer #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned BEAT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              drain_en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd,
    output logic [BEAT_W-1:0] m_data,
    output logic              m_valid,
    output logic              m_last,
    input  logic              m_ready,
    output logic              busy
`ifdef FIFO_DRAIN_CNT_EN
    ,
    output logic [15:0]       drain_cnt
`endif
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StLo   = 2'd1;
    localparam logic [1:0] StHi   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] ent_q, ent_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              rd_q;
    logic              busy_q;
    logic              hs;
    logic              capture;

    assign hs      = valid_q & m_ready;
    // A new entry is taken from IDLE, or straight after the high beat is accepted.
    assign capture = drain_en & ~fifo_empty &
                     ((state_q == StIdle) | ((state_q == StHi) & hs));

    always_comb begin
        state_d = state_q;
        ent_d   = ent_q;
        valid_d = valid_q;
        last_d  = last_q;
        case (state_q)
            StIdle: begin
                if (capture) begin
                    state_d = StLo;
                    ent_d   = fifo_data;
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                end
            end
            StLo: begin
                if (hs) begin
                    state_d = StHi;
                    last_d  = 1'b1;
                end
            end
            StHi: begin
                if (hs) begin
                    if (capture) begin
                        state_d = StLo;
                        ent_d   = fifo_data;
                        valid_d = 1'b1;
                        last_d  = 1'b0;
                    end else begin
                        state_d = StIdle;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ent_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            rd_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ent_q   <= ent_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            rd_q    <= capture;
            busy_q  <= (state_d != StIdle);
        end
    end

`ifdef FIFO_DRAIN_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (capture) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign drain_cnt = cnt_q;
`endif

    assign m_data  = last_q ? ent_q[2*BEAT_W-1:BEAT_W] : ent_q[BEAT_W-1:0];
    assign m_valid = valid_q;
    assign m_last  = last_q;
    assign fifo_rd = rd_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_fifo_drain_serializer.sv
// Bench for fifo_drain_serializer: FIFO model plus expected-beat queue checked every cycle,
// with directed scenarios pinned by literal expectations.
module tb_fifo_drain_serializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        drain_en;
    logic        fifo_empty;
    logic [63:0] fifo_data;
    logic        fifo_rd;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_last;
    logic        m_ready;
    logic        busy;
`ifdef FIFO_DRAIN_CNT_EN
    logic [15:0] drain_cnt;
    logic [15:0] cnt_base;
`endif

    fifo_drain_serializer #(.DATA_W(64), .BEAT_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .drain_en   (drain_en),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd    (fifo_rd),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_last     (m_last),
        .m_ready    (m_ready),
        .busy       (busy)
`ifdef FIFO_DRAIN_CNT_EN
        ,
        .drain_cnt  (drain_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rd_count = 0;
    logic held   = 1'b0;

    logic [63:0] fifo_q[$];
    logic [32:0] exp_q[$];   // {last, data}
    logic [31:0] log_data[$];
    logic        log_last[$];
    int          log_cyc[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic refresh();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = (fifo_q.size() == 0) ? 64'h0 : fifo_q[0];
    endtask

    task automatic push(input logic [63:0] v);
        fifo_q.push_back(v);
        refresh();
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!m_valid && n < 20) begin
            tick(1);
            n++;
        end
        chk("wait_valid_timeout", 64'(m_valid), 64'd1);
    endtask

    task automatic clear_log();
        log_data.delete();
        log_last.delete();
        log_cyc.delete();
        rd_count = 0;
    endtask

    // Reference: every pop queues its two beats; every handshake must match the queue head.
    always @(negedge clk) begin
        logic [63:0] e;
        logic [32:0] b;
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            cyc++;
            if (held) chk("valid_hold", 64'(m_valid), 64'd1);
            if (fifo_rd) begin
                rd_count++;
                chk("rd_after_prev_done", 64'(exp_q.size()), 64'd0);
                chk("rd_fifo_nonempty", 64'(fifo_q.size() > 0), 64'd1);
                if (fifo_q.size() > 0) begin
                    e = fifo_q.pop_front();
                    refresh();
                    exp_q.push_back({1'b0, e[31:0]});
                    exp_q.push_back({1'b1, e[63:32]});
                end
            end
            chk("busy_vs_valid", 64'(busy), 64'(m_valid));
            if (m_valid) chk("valid_has_beat", 64'(exp_q.size() > 0), 64'd1);
            if (m_valid && m_ready && exp_q.size() > 0) begin
                b = exp_q.pop_front();
                chk("beat_data", 64'(m_data), 64'(b[31:0]));
                chk("beat_last", 64'(m_last), 64'(b[32]));
                log_data.push_back(m_data);
                log_last.push_back(m_last);
                log_cyc.push_back(cyc);
            end
            held = m_valid && !m_ready;
        end
    end

    initial begin
        int lb;
        rst_n    = 1'b0;
        drain_en = 1'b0;
        m_ready  = 1'b0;
        refresh();
        #1;
        chk("rst_valid", 64'(m_valid), 64'd0);
        chk("rst_last", 64'(m_last), 64'd0);
        chk("rst_rd", 64'(fifo_rd), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_data", 64'(m_data), 64'd0);
        #10 rst_n = 1'b1;
        tick(2);
        chk("idle_valid", 64'(m_valid), 64'd0);

        // Single entry with consumer always ready
        clear_log();
        m_ready = 1'b1;
        push(64'h89AB_CDEF_0123_4567);
        drain_en = 1'b1;
        tick(6);
        chk("single_beats", 64'(log_data.size()), 64'd2);
        if (log_data.size() == 2) begin
            chk("single_lo", 64'(log_data[0]), 64'h0123_4567);
            chk("single_lo_last", 64'(log_last[0]), 64'd0);
            chk("single_hi", 64'(log_data[1]), 64'h89AB_CDEF);
            chk("single_hi_last", 64'(log_last[1]), 64'd1);
        end
        chk("single_rd", 64'(rd_count), 64'd1);
        chk("single_empty", 64'(fifo_empty), 64'd1);
        chk("single_idle", 64'(busy), 64'd0);

        // Back-to-back: 16 entries, no gaps
        drain_en = 1'b0;
        clear_log();
`ifdef FIFO_DRAIN_CNT_EN
        cnt_base = drain_cnt;
`endif
        for (int i = 0; i < 16; i++) push({i[31:0], i[31:0]});
        drain_en = 1'b1;
        tick(40);
        chk("b2b_beats", 64'(log_data.size()), 64'd32);
        if (log_data.size() == 32) begin
            chk("b2b_no_gap", 64'(log_cyc[31] - log_cyc[0]), 64'd31);
            chk("b2b_last_data", 64'(log_data[31]), 64'd15);
            chk("b2b_last_flag", 64'(log_last[31]), 64'd1);
            chk("b2b_mid_data", 64'(log_data[10]), 64'd5);
        end
        chk("b2b_rd", 64'(rd_count), 64'd16);
`ifdef FIFO_DRAIN_CNT_EN
        chk("b2b_cnt", 64'(drain_cnt - cnt_base), 64'd16);
`endif

        // Backpressure in LO for 5 cycles
        m_ready  = 1'b0;
        drain_en = 1'b0;
        clear_log();
        push(64'h1111_2222_3333_4444);
        push(64'h5555_6666_7777_8888);
        drain_en = 1'b1;
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            chk("bp_data", 64'(m_data), 64'h3333_4444);
            chk("bp_last", 64'(m_last), 64'd0);
            tick(1);
        end
        chk("bp_no_rd", 64'(rd_count), 64'd1);
        chk("bp_no_beat", 64'(log_data.size()), 64'd0);
        m_ready = 1'b1;
        tick(1);
        chk("bp_resume", 64'(log_data.size()), 64'd1);
        tick(6);
        chk("bp_total", 64'(log_data.size()), 64'd4);
        chk("bp_rd", 64'(rd_count), 64'd2);

        // drain_en drop in LO with 3 entries queued
        m_ready  = 1'b0;
        drain_en = 1'b0;
        clear_log();
        push(64'hA0A0_A0A0_0A0A_0A0A);
        push(64'hB1B1_B1B1_1B1B_1B1B);
        push(64'hC2C2_C2C2_2C2C_2C2C);
        drain_en = 1'b1;
        wait_valid();
        drain_en = 1'b0;
        m_ready  = 1'b1;
        tick(6);
        chk("den_fifo_left", 64'(fifo_q.size()), 64'd2);
        chk("den_rd", 64'(rd_count), 64'd1);
        chk("den_beats", 64'(log_data.size()), 64'd2);
        if (log_data.size() == 2) chk("den_hi", 64'(log_data[1]), 64'hA0A0_A0A0);
        chk("den_idle", 64'(busy), 64'd0);
        drain_en = 1'b1;
        tick(8);
        chk("den_flushed", 64'(fifo_q.size()), 64'd0);

        // Asynchronous reset while holding the HI beat
        drain_en = 1'b0;
        m_ready  = 1'b0;
        clear_log();
        push(64'hDEAD_BEEF_CAFE_F00D);
        push(64'h1357_9BDF_2468_ACE0);
        drain_en = 1'b1;
        wait_valid();
        m_ready = 1'b1;
        tick(1);
        m_ready = 1'b0;
        chk("pre_rst_hi", 64'(m_last), 64'd1);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("arst_valid", 64'(m_valid), 64'd0);
        chk("arst_last", 64'(m_last), 64'd0);
        chk("arst_rd", 64'(fifo_rd), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        #3 rst_n = 1'b1;
        clear_log();
        m_ready = 1'b1;
        tick(6);
        lb = log_data.size();
        chk("post_rst_beats", 64'(lb), 64'd2);
        if (lb == 2) begin
            chk("post_rst_lo", 64'(log_data[0]), 64'h2468_ACE0);
            chk("post_rst_hi", 64'(log_data[1]), 64'h1357_9BDF);
        end
        chk("post_rst_empty", 64'(fifo_empty), 64'd1);

`ifdef FIFO_DRAIN_CNT_EN
        // Counter wrap
        dut.cnt_q = 16'hFFFF;
        push(64'h0000_0001_0000_0002);
        tick(5);
        chk("cnt_wrap", 64'(drain_cnt), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_drain_serializer.md
# fifo_drain_serializer

Read-side drain engine for the 64-bit, 16-entry `fifo_mem` buffer. It pops one 64-bit entry at a time from the FIFO and presents it to the RV32IM core side as two 32-bit beats on a valid/ready stream, low word first. It sits between the FIFO's `rd`/`fifo_empty`/`data_out` pins and any 32-bit consumer, such as a CSR-mapped receive port or a spike-packet decoder.

## Interface
- `DATA_W`, 64: FIFO entry width. Must be exactly 2×`BEAT_W`.
- `BEAT_W`, 32: output beat width.
- `clk` input 1: single clock. All state updates on the posedge.
- `rst_n` input 1: asynchronous, active-low reset.
- `drain_en` input 1: when high, new entries may be popped. When low, only the entry in flight completes.
- `fifo_empty` input 1: from the FIFO.
- `fifo_data` input `DATA_W`: FIFO `data_out`, combinational from the read pointer.
- `fifo_rd` output 1: pop request to the FIFO `rd` pin. Registered, single-cycle pulse.
- `m_data` output `BEAT_W`: current beat.
- `m_valid` output 1: beat valid.
- `m_last` output 1: high on the second (high-word) beat of an entry.
- `m_ready` input 1: consumer accepts the beat.
- `busy` output 1: high when the state is not IDLE.

## Operation
- States:
  - IDLE: no entry held.
  - LO: presenting bits [31:0].
  - HI: presenting bits [63:32].
- Entry register `ent_q[63:0]` holds the captured entry. `m_data` is always selected from `ent_q`, never directly from `fifo_data`.
- IDLE → LO when `drain_en & ~fifo_empty`. On that edge:
  - `ent_q <= fifo_data`
  - `fifo_rd <= 1`
  - `m_valid <= 1`
  - `m_last <= 0`
- LO → HI on `m_valid & m_ready`. On that edge, `m_last <= 1`.
- HI on `m_valid & m_ready`:
  - If `drain_en & ~fifo_empty`: capture the next entry exactly as from IDLE and go to LO (back-to-back).
  - Otherwise: go to IDLE with `m_valid <= 0` and `m_last <= 0`.
- `fifo_rd` is high for exactly one cycle per captured entry and is 0 on all other cycles. The FIFO advances its pointer on the negedge inside that cycle, so `fifo_empty` is settled before the next posedge. No entry is ever popped twice or skipped.
- Stream rules:
  - Once `m_valid` is high, `m_data` and `m_last` hold stable until `m_ready`.
  - `m_valid` never drops without a handshake.
  - `m_ready` may be high before `m_valid`; it has no effect while `m_valid` is 0.
- `drain_en` falling in LO or HI does not abort. Both beats of the current entry are delivered, then the block goes to IDLE.
- `fifo_empty` is ignored outside the capture decision. `fifo_data` is sampled only on capture edges.
- Reset (asynchronous, any state):
  - State IDLE; `ent_q` = 0.
  - `fifo_rd`, `m_valid`, `m_last`, `busy` all 0; `m_data` = 0.
  - An entry already popped but not fully delivered is discarded.

## Timing
- Latency from `fifo_empty` falling (with `drain_en` high in IDLE) to `m_valid` high: 1 posedge.
- `fifo_rd` rises on the same edge as `m_valid`.
- Peak throughput, with `m_ready` held high and the FIFO non-empty: 1 beat/cycle, 1 entry per 2 cycles, no bubble between entries.
- Stall tolerance: any number of cycles with `m_ready` low in LO or HI; state and outputs are frozen.
- `busy` is registered and equals (state ≠ IDLE).

## Configuration
- `FIFO_DRAIN_CNT_EN`:
  - Defined: adds output `drain_cnt[15:0]`.
    - Increments by 1 on every edge where `fifo_rd` is set.
    - Wraps 0xFFFF → 0x0000.
    - Reset value 0.
  - Undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset mid-entry:
  - Stimulus: assert `rst_n`=0 asynchronously while in HI with `m_valid`=1.
  - Required: `m_valid`, `m_last`, `fifo_rd`, `busy` go 0 immediately, with no clock edge. After release, the next entry pops normally.
- Single entry, `m_ready`=1:
  - Stimulus: FIFO holds 0x89ABCDEF_01234567.
  - Required: beats 0x01234567 (`m_last`=0), then 0x89ABCDEF (`m_last`=1). `fifo_rd` pulses once. Back to IDLE; `fifo_empty`=1.
- Back-to-back entries:
  - Stimulus: 16 entries with value i in both halves.
  - Required: 32 consecutive beats with no gap. `fifo_rd` pulses 16 times. With `FIFO_DRAIN_CNT_EN`, `drain_cnt`=16.
- Backpressure:
  - Stimulus: `m_ready` low for 5 cycles in LO.
  - Required: `m_data` stable; no `fifo_rd`; progress resumes on the first cycle with `m_ready`=1.
- `drain_en` drop:
  - Stimulus: deassert `drain_en` during LO with 3 entries queued.
  - Required: HI beat still delivered, then IDLE. FIFO keeps 2 entries. `fifo_rd` count = 1.
- Counter wrap (macro on):
  - Stimulus: force `drain_cnt`=0xFFFF, then pop 1 entry.
  - Required: `drain_cnt`=0x0000.
